// File: rtl/sequential_left_shifter_pkg.sv
// Shared ALU definitions for the multi-cycle left shifter:
// FSM state encoding, datapath word width and the largest in-range shift amount.
package sequential_left_shifter_pkg;

    localparam int WORD_W    = 32;
    localparam int SHAMT_MAX = 31;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sequential_left_shifter_shl_step.sv
// shl_step: combinational one-bit left shift with a per-step overflow bit.
// Ports: i_d (value before shift), o_q (shifted value), o_ovf (sign bit changes).
module shl_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_ovf
);

    assign o_q   = {i_d[W-2:0], 1'b0};
    // The new sign bit is the old bit W-2, so a mismatch means the sign flips.
    assign o_ovf = i_d[W-1] ^ i_d[W-2];

endmodule

// File: rtl/sequential_left_shifter.sv
// sequential_left_shifter: shifts A left by B, one bit per clock, zero fill.
// Ports: clk, rst (sync, high), start/A/B request, result/ovf output,
// busy (not IDLE), done (one-cycle pulse). Overflow tracking: SHL_OVF_EN.
module sequential_left_shifter
    import sequential_left_shifter_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int SH_W = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;

    logic             w_big;
    logic             w_zero;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_ovf;

    // Full-width compare: any bit above the shift field forces the shortcut.
    assign w_big  = B > WIDTH'(SHAMT_MAX);
    assign w_zero = B == '0;

    shl_step #(
        .W (WIDTH)
    ) u_step (
        .i_d   (r_result),
        .o_q   (w_step_q),
        .o_ovf (w_step_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            w_big: begin
                                r_result <= '0;
                                r_state  <= ST_DONE;
                            end
                            w_zero: begin
                                r_result <= A;
                                r_state  <= ST_DONE;
                            end
                            default: begin
                                r_result <= A;
                                r_cnt    <= CNT_W'(B[SH_W-1:0]);
                                r_state  <= ST_SHIFT;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    r_result <= w_step_q;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1))
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SHL_OVF_EN
    logic r_ovf;

    // Sticky across the operation; cleared only when a new start is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start)
                        r_ovf <= w_big && (A != '0);
                end
                ST_SHIFT: begin
                    if (w_step_ovf)
                        r_ovf <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = w_step_ovf;
    assign ovf          = 1'b0;
`endif

    assign result = r_result;
    assign busy   = r_state != ST_IDLE;
    assign done   = r_state == ST_DONE;

endmodule

// File: tb/tb_sequential_left_shifter.sv
// Scoreboard bench for sequential_left_shifter: directed and random shifts
// checked against an arithmetic model, including latency and reset abort.
module tb_sequential_left_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        ovf;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic        hold_valid = 1'b0;
    logic [31:0] hold_res;
    logic        hold_ovf;

    sequential_left_shifter dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .result (result),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst)
            hold_valid = 1'b0;
    end

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Reference: plain shift; overflow means the top B+1 bits of A were
    // not all equal, i.e. shifting back arithmetically does not restore A.
    function automatic exp_t model(logic [31:0] a, logic [31:0] b, int c0);
        exp_t e;
        logic [63:0] wide;
        logic signed [31:0] back;
        e.cyc = (b == 0 || b > 31) ? c0 : c0 + int'(b);
        if (b > 31) begin
            e.res = 32'h0;
            e.ovf = (a != 0);
        end else begin
            wide  = {32'h0, a} << b;
            e.res = wide[31:0];
            back  = $signed(e.res) >>> b;
            e.ovf = (back != $signed(a));
        end
`ifndef SHL_OVF_EN
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done pulse and checks holding.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            total = total + 1;
            if (q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none",
                         cyc);
            end else begin
                e = q.pop_front();
                check("result", result, e.res);
                check("ovf", {31'h0, ovf}, {31'h0, e.ovf});
                check("done_cycle", cyc, e.cyc);
                hold_valid = 1'b1;
                hold_res   = e.res;
                hold_ovf   = e.ovf;
            end
        end else if (!busy && hold_valid && !rst) begin
            check("result_hold", result, hold_res);
            check("ovf_hold", {31'h0, ovf}, {31'h0, hold_ovf});
        end
    end

    // Called at a negedge with the DUT idle; returns at the first idle negedge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit junk);
        exp_t e;
        int lat;
        e   = model(a, b, cyc + 1);
        lat = e.cyc - (cyc + 1);
        q.push_back(e);
        start = 1'b1;
        A     = a;
        B     = b;
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            check("busy_inflight", {31'h0, busy}, 32'h1);
            if (junk) begin
                start = 1'b1;
                A     = 32'h0000FFFF;
                B     = 32'h1;
            end else begin
                start = 1'b0;
                A     = $urandom;
                B     = $urandom;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("busy_idle", {31'h0, busy}, 32'h0);
        check("done_seen", q.size(), 0);
        q.delete();
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_result"}, result, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_ovf"}, {31'h0, ovf}, 32'h0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check_reset_state("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("rst_exit");

        run_op(32'h0000000F, 32'd4, 1'b0);
        run_op(32'h00000001, 32'd31, 1'b0);
        run_op(32'h00001234, 32'd40, 1'b0);
        run_op(32'hDEADBEEF, 32'd0, 1'b0);
        run_op(32'h00000003, 32'd8, 1'b1);
        run_op(32'h80000000, 32'h00000100, 1'b0);
        run_op(32'h00000000, 32'hFFFFFFFF, 1'b0);
        run_op(32'hC0000001, 32'd1, 1'b0);

        // Abort an in-flight shift with a reset at edge 6.
        start = 1'b1;
        A     = 32'h1;
        B     = 32'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("abort");
        repeat (2) @(negedge clk);
        check("abort_no_done", {31'h0, done}, 32'h0);
        run_op(32'h00000002, 32'd1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            if (n % 3 == 0)
                a = a >> $urandom_range(0, 31);
            b = ($urandom_range(0, 9) == 0) ? $urandom
                                            : 32'($urandom_range(0, 40));
            run_op(a, b, $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequential_left_shifter.md
# sequential_left_shifter

Multi-cycle left shifter for the ALU datapath. It is the left-direction counterpart of the single-cycle arithmetic right shifter. It shifts operand A left by B bit positions, one bit per clock, filling with zeros. A start/busy/done handshake lets the multi-cycle control unit stall while it works. It replaces a full barrel shifter for SLL/SLLV where area matters more than latency.

## Interface
Parameters:
- WIDTH, 32, operand and result width (fixed at 32 for the current datapath)
- CNT_W, 6, step counter width (must hold values 0..WIDTH)

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  32  value to shift; sampled with start
- B  input  32  shift amount, unsigned; sampled with start
- result  output  32  shifted value; holds until the next accepted start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; result is valid in that cycle
- ovf  output  1  arithmetic-overflow flag; valid with done and held with result

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with start=1 at edge 0:
  - B > 31: result ← 0, ovf ← (A ≠ 0), next state DONE.
  - B == 0: result ← A, ovf ← 0, next state DONE.
  - Otherwise: result ← A, cnt ← B[4:0], ovf ← 0, next state SHIFT.
- SHIFT, every edge:
  - result ← {result[30:0], 1'b0}, cnt ← cnt − 1.
  - When cnt reaches 0 on this edge, the next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- start is ignored while busy. Operands are not re-sampled. There is no queueing.
- B is compared as a full 32-bit unsigned value. Only B[4:0] is loaded into cnt.
- Reset is synchronous and takes priority over everything:
  - state IDLE, result 0, ovf 0, cnt 0.
  - busy 0 and done 0 in the cycle after the reset edge.
  - An in-flight operation is abandoned. No done pulse is produced for it.

## Timing
- start is accepted at edge 0. For N = B in 1..31, done is high in the cycle after edge N, so latency is N+1 cycles including the DONE cycle.
- For B == 0 or B > 31, done is high in the cycle after edge 0.
- busy rises in the cycle after edge 0. It falls in the cycle after done.
- The earliest next start is accepted at the edge that leaves DONE plus one, i.e. in the first IDLE cycle.
- result is stable from done until the next accepted start. ovf follows the same rule.

## Configuration
- SHL_OVF_EN defined:
  - ovf is sticky over the operation.
  - It is set on any SHIFT edge where result[31] ≠ result[30] before that shift, which means the sign bit changed.
  - It is also set by the B > 31 shortcut when A ≠ 0.
- SHL_OVF_EN undefined:
  - The overflow logic is removed and ovf is tied to 0.
  - The port still exists.

## Structure
- A shared ALU package holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - WORD_W=32
  - SHAMT_MAX=31
- One sub-module, shl_step, is natural. It is a combinational single-bit left shift that also produces the per-step overflow bit. The top level owns the FSM, the counter and the result register.

## Test plan
- A=0x0000000F, B=4 -> result=0x000000F0, done after edge 4, ovf=0, busy high for edges 1..4 plus the DONE cycle.
- A=0x00000001, B=31 -> result=0x80000000, done after edge 31, ovf=1 with SHL_OVF_EN, ovf=0 without.
- A=0x00001234, B=40 -> result=0, done after edge 0, ovf=1 with SHL_OVF_EN; then B=0, A=0xDEADBEEF -> result=0xDEADBEEF, ovf=0, done after edge 0.
- A=0x3, B=8 started, then start=1 with A=0xFFFF, B=1 at edges 2..5 -> second request ignored, result=0x300, a single done pulse.
- A=0x1, B=20, rst=1 at edge 6 -> result=0, busy=0, no done pulse. A new start with A=0x2, B=1 after reset -> result=0x4.
